// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// It also suppresses x0 writes, supports a synchronous flush and counts retired results.
module mem_wb_skid #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NOP_ADDR = 0,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [ADDR_W-1:0] NOP = ADDR_W'(NOP_ADDR);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
  } slot_t;

  slot_t main_q, skid_q, in_d;
  logic  main_valid, skid_valid;
  logic  accept, drain;

  // mem_ready depends only on a flop, so wb_ready never reaches it combinationally.
  assign mem_ready = ~skid_valid;
  assign accept    = mem_valid & mem_ready;
  assign drain     = main_valid & wb_ready;
  assign in_d      = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata};

  assign wb_valid = main_valid;
  assign wb_wd    = main_valid ? main_q.wd : NOP;
  assign wb_wdata = main_valid ? main_q.wdata : '0;
  assign wb_wreg  = main_valid & main_q.wreg & (main_q.wd != '0);

  // NOTE: every flop here, payloads included, is async-reset so nothing stale
  // is visible after rst drops; this is only cheap because the storage is two slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      retire_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge state and the order of the statements below does not matter.
      if (drain) retire_cnt <= retire_cnt + CNT_W'(1);

      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
        main_q     <= '0;
        skid_q     <= '0;
      end else if (skid_valid) begin
        // FULL: accept is impossible, so only a drain can move data.
        if (drain) begin
          main_q     <= skid_q;
          skid_q     <= '0;
          skid_valid <= 1'b0;
        end
      end else if (main_valid) begin
        if (accept && drain) begin
          main_q <= in_d;
        end else if (accept) begin
          skid_q     <= in_d;
          skid_valid <= 1'b1;
        end else if (drain) begin
          main_valid <= 1'b0;
          main_q     <= '0;
        end
      end else if (accept) begin
        main_q     <= in_d;
        main_valid <= 1'b1;
      end
    end
  end

endmodule
